// File: rtl/tracking_loop_arbiter.sv
// Round-robin arbiter that time-shares one tracking_loops instance among NUM_CHANNELS channels.
// Requests are latched per channel; the FSM issues start, waits for ready (or times out) and returns done.

module tracking_loop_arbiter_chan (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req_i,
  input  logic gnt_i,
  output logic eff_o,
  output logic ovr_o
);
  logic pend_q, pend_d;

  assign eff_o  = (pend_q | req_i) & en_i;
  // A request landing on its own grant cycle is consumed by that grant, not flagged.
  assign ovr_o  = req_i & pend_q & en_i & ~gnt_i;
  assign pend_d = en_i & (pend_q | req_i) & ~gnt_i;

  always_ff @(posedge clk or posedge rst)
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
endmodule

module tracking_loop_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_WIDTH     = 2,
  parameter int TIMEOUT      = 1023,
  parameter int TO_WIDTH     = 10
) (
  input  logic                    clk,
  input  logic                    global_reset,
  input  logic [NUM_CHANNELS-1:0] ch_enable,
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic                    loops_ready,
  output logic [CH_WIDTH-1:0]     sel,
  output logic                    loops_start,
  output logic [NUM_CHANNELS-1:0] done,
  output logic                    busy,
  output logic [NUM_CHANNELS-1:0] overrun,
  output logic                    timeout
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_e;

  localparam logic [CH_WIDTH-1:0] LAST_RST = CH_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_WIDTH'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [CH_WIDTH-1:0]     sel_q, sel_d, last_q, last_d, gnt_idx;
  logic [TO_WIDTH-1:0]     timer_q, timer_d;
  logic [NUM_CHANNELS-1:0] eff, gnt_oh;
  logic                    gnt_vld;

  function automatic logic [CH_WIDTH-1:0] rot(input logic [CH_WIDTH-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_CHANNELS;
    return CH_WIDTH'(s);
  endfunction

  tracking_loop_arbiter_chan u_chan [NUM_CHANNELS-1:0] (
    .clk   (clk),
    .rst   (global_reset),
    .en_i  (ch_enable),
    .req_i (req),
    .gnt_i (gnt_oh),
    .eff_o (eff),
    .ovr_o (overrun)
  );

  // Scan from farthest to nearest so the channel right after last wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_CHANNELS; k >= 1; k--) begin
      if (eff[rot(last_q, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rot(last_q, k);
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      gnt_oh[i] = (state_q == S_IDLE) && gnt_vld && (gnt_idx == CH_WIDTH'(i));
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    timer_d     = timer_q;
    loops_start = 1'b0;
    timeout     = 1'b0;
    unique case (state_q)
      S_IDLE: if (gnt_vld) begin
        sel_d   = gnt_idx;
        state_d = S_START;
      end
      S_START: begin
        loops_start = 1'b1;
        timer_d     = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (loops_ready) state_d = S_DONE;
        else if (timer_q == TO_LAST) begin
          timeout = 1'b1;
          last_d  = sel_q;
          state_d = S_IDLE;
        end else timer_d = timer_q + TO_WIDTH'(1);
      end
      S_DONE: begin
        last_d  = sel_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      last_q  <= LAST_RST;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    done = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      done[i] = (state_q == S_DONE) && (sel_q == CH_WIDTH'(i));
  end

  assign busy = (state_q != S_IDLE);
  assign sel  = sel_q;
endmodule
